vx_axi_mem_responder: RTL



---
 rtl/vx_axi_mem_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vx_axi_mem_responder.sv
// vx_axi_mem_responder: AXI4 slave backed by a single-port RAM of full-width words.
// Serves one burst at a time (INCR, full width): strobed write bursts with a tagged
// B response, and read bursts with tagged R beats and rlast.
module vx_axi_mem_responder #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                    ap_clk,
    input  logic                    reset,

    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,

    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,

    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,

    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,

    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,

    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic                    prio_wr;     // 1: write channel wins a simultaneous request
    logic [DEPTH_LOG2-1:0]   idx;         // next word to write, or next word to prefetch on reads
    logic [8:0]              beats_left;  // beats remaining, including the one in flight
    logic [ID_WIDTH-1:0]     id_q;
    logic                    err_q;       // sticky wlast/count disagreement for the current write
    logic [DATA_WIDTH-1:0]   rdata_q;     // RAM output register, only reloaded on a read issue
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    grant_w;
    logic                    grant_r;
    logic                    aw_fire;
    logic                    ar_fire;
    logic                    w_fire;
    logic                    b_fire;
    logic                    r_fire;
    logic                    final_beat;
    logic                    rd_en;
    logic [DEPTH_LOG2-1:0]   rd_idx;

    // Byte address to word index: drop the in-word offset, keep DEPTH_LOG2 bits.
    function automatic logic [DEPTH_LOG2-1:0] idx_of(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word_addr;
        word_addr = addr >> OFF_BITS;
        return word_addr[DEPTH_LOG2-1:0];
    endfunction

    assign grant_w    = s_axi_awvalid && (prio_wr || !s_axi_arvalid);
    assign grant_r    = s_axi_arvalid && !grant_w;
    assign aw_fire    = (state == S_IDLE)  && grant_w;
    assign ar_fire    = (state == S_IDLE)  && grant_r;
    assign w_fire     = (state == S_WDATA) && s_axi_wvalid;
    assign b_fire     = (state == S_WRESP) && s_axi_bready;
    assign r_fire     = (state == S_RDATA) && s_axi_rready;
    assign final_beat = (beats_left == 9'd1);
    assign rd_en      = ar_fire || (r_fire && !final_beat);
    assign rd_idx     = ar_fire ? idx_of(s_axi_araddr) : idx;

    // State register.
    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if      (aw_fire) state_next = S_WDATA;
                else if (ar_fire) state_next = S_RDATA;
            end
            S_WDATA: if (w_fire && final_beat) state_next = S_WRESP;
            S_WRESP: if (b_fire)               state_next = S_IDLE;
            S_RDATA: if (r_fire && final_beat) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Channel outputs decoded from the current state and captured burst context.
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        busy          = 1'b1;
        unique case (state)
            S_IDLE: begin
                s_axi_awready = grant_w;
                s_axi_arready = grant_r;
                busy          = 1'b0;
            end
            S_WDATA: s_axi_wready = 1'b1;
            S_WRESP: s_axi_bvalid = 1'b1;
            S_RDATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = final_beat;
            end
            default: busy = 1'b0;
        endcase
    end

    assign s_axi_bid   = id_q;
    assign s_axi_bresp = err_q ? 2'b10 : 2'b00;
    assign s_axi_rid   = id_q;
    assign s_axi_rresp = 2'b00;
    assign s_axi_rdata = rdata_q;

    // Burst context: arbitration flag, ID, word index, beat count and error flag.
    always_ff @(posedge ap_clk) begin
        if (reset) begin
            prio_wr    <= 1'b1;
            idx        <= '0;
            beats_left <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
        end else if (aw_fire) begin
            prio_wr    <= ~prio_wr;
            id_q       <= s_axi_awid;
            idx        <= idx_of(s_axi_awaddr);
            beats_left <= {1'b0, s_axi_awlen} + 9'd1;
            err_q      <= 1'b0;
        end else if (ar_fire) begin
            prio_wr    <= ~prio_wr;
            id_q       <= s_axi_arid;
            idx        <= idx_of(s_axi_araddr) + 1'b1;
            beats_left <= {1'b0, s_axi_arlen} + 9'd1;
        end else if (w_fire) begin
            idx        <= idx + 1'b1;
            beats_left <= beats_left - 9'd1;
            if (s_axi_wlast != final_beat) err_q <= 1'b1;
        end else if (r_fire && !final_beat) begin
            idx        <= idx + 1'b1;
            beats_left <= beats_left - 9'd1;
        end
    end

    // Single-port RAM: strobed word write on W fire, registered read on read issue.
    always_ff @(posedge ap_clk) begin
        // NOTE: the storage array is deliberately not reset; contents survive a reset.
        if (w_fire && !reset) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
        if (rd_en && !reset) rdata_q <= mem[rd_idx];
    end

endmodule
